// File: rtl/edge_pkg.sv
// Shared types and constants for the edge-detection address generator.
// The word stride and dimension widths live here so both channels agree on them.
package edge_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FINISH
   } state_e;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned ADDR_W         = 32;
   localparam int unsigned DIM_W          = 16;
   localparam int unsigned WPR_W          = 15;
   localparam int unsigned CNT_W          = 32;

   // A partial trailing word still occupies a full word slot.
   function automatic logic [WPR_W-1:0] words_per_row(input logic [DIM_W-1:0] width);
      logic [DIM_W:0] padded;
      padded = {1'b0, width} + (DIM_W+1)'(BYTES_PER_WORD - 1);
      return WPR_W'(padded >> $clog2(BYTES_PER_WORD));
   endfunction

endpackage

// File: rtl/edge_word_counter.sv
// Word counter with a byte-address shadow: loads a base, steps by one word per
// accept and reports whether more words remain and whether the next accept is the last.
module edge_word_counter
   import edge_pkg::*;
#(
   parameter int unsigned STRIDE = BYTES_PER_WORD
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic              inc_i,
   input  logic [CNT_W-1:0]  total_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              more_o,
   output logic              last_o
);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   // NOTE: next-state defaults come first so every path assigns them and no latch is inferred.
   always_comb begin
      cnt_d  = cnt_q;
      addr_d = addr_q;
      if (load_i) begin
         cnt_d  = '0;
         addr_d = base_i;
      end else if (inc_i) begin
         cnt_d  = cnt_q + CNT_W'(1);
         addr_d = addr_q + ADDR_W'(STRIDE);
      end
   end

   // NOTE: reset is synchronous, and state registers use non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         cnt_q  <= '0;
         addr_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         addr_q <= addr_d;
      end
   end

   assign addr_o = addr_q;
   assign more_o = cnt_q < total_i;
   assign last_o = (cnt_q + CNT_W'(1)) == total_i;

endmodule

// File: rtl/edge_addr_gen.sv
// Frame sequencer: streams row-major read requests under an in-flight credit limit,
// issues one write per filter result, and pulses done after the final write is accepted.
module edge_addr_gen
   import edge_pkg::*;
#(
   parameter int unsigned MAX_INFLIGHT = 4
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_raddr,
   input  logic [ADDR_W-1:0] start_waddr,
   input  logic [DIM_W-1:0]  img_width,
   input  logic [DIM_W-1:0]  img_height,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_ready,
   input  logic              rd_data_valid,
   input  logic              result_valid,
   output logic              wr_req,
   output logic [ADDR_W-1:0] wr_addr,
   input  logic              wr_ready,
   output logic              busy,
   output logic              done
);

   localparam int unsigned IF_W = 4;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] total_q, total_d;
   logic [IF_W-1:0]  inflight_q, inflight_d;
   logic [7:0]       pending_q, pending_d;

   logic load, rd_acc, wr_acc, rd_ret;
   logic rd_more, rd_last_unused, wr_more, wr_last;

   assign load   = (state_q == IDLE) && start;
   assign rd_req = (state_q == RUN) && rd_more && (inflight_q < IF_W'(MAX_INFLIGHT));
   assign wr_req = (state_q == RUN) && (pending_q != '0) && wr_more;
   assign rd_acc = rd_req && rd_ready;
   assign wr_acc = wr_req && wr_ready;
   // A return with nothing outstanding is a protocol error and must not underflow the credit.
   assign rd_ret = rd_data_valid && (inflight_q != '0);
   assign busy   = (state_q == RUN);
   assign done   = (state_q == FINISH);

   edge_word_counter u_rd_cnt (
      .clk     (clk),
      .n_rst   (n_rst),
      .load_i  (load),
      .base_i  (start_raddr),
      .inc_i   (rd_acc),
      .total_i (total_q),
      .addr_o  (rd_addr),
      .more_o  (rd_more),
      .last_o  (rd_last_unused)
   );

   edge_word_counter u_wr_cnt (
      .clk     (clk),
      .n_rst   (n_rst),
      .load_i  (load),
      .base_i  (start_waddr),
      .inc_i   (wr_acc),
      .total_i (total_q),
      .addr_o  (wr_addr),
      .more_o  (wr_more),
      .last_o  (wr_last)
   );

   always_comb begin
      state_d    = state_q;
      total_d    = total_q;
      inflight_d = inflight_q;
      pending_d  = pending_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               total_d    = CNT_W'(words_per_row(img_width)) * CNT_W'(img_height);
               inflight_d = '0;
               pending_d  = '0;
               state_d    = (total_d == '0) ? FINISH : RUN;
            end
         end
         RUN: begin
            if (rd_acc && !rd_ret)      inflight_d = inflight_q + IF_W'(1);
            else if (!rd_acc && rd_ret) inflight_d = inflight_q - IF_W'(1);
            if (result_valid && !wr_acc && (pending_q != 8'hFF)) pending_d = pending_q + 8'd1;
            else if (wr_acc && !result_valid)                    pending_d = pending_q - 8'd1;
            if (wr_acc && wr_last) state_d = FINISH;
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         total_q    <= '0;
         inflight_q <= '0;
         pending_q  <= '0;
      end else begin
         state_q    <= state_d;
         total_q    <= total_d;
         inflight_q <= inflight_d;
         pending_q  <= pending_d;
      end
   end

endmodule

// File: tb/tb_edge_addr_gen.sv
// Bench for edge_addr_gen: a frame-level model checked every cycle, directed
// scenarios with hand-computed address lists, and a bus responder for read returns.
module tb_edge_addr_gen;

   localparam int MAXI = 4;

   logic        clk = 1'b0;
   logic        n_rst, start;
   logic [31:0] start_raddr, start_waddr;
   logic [15:0] img_width, img_height;
   logic        rd_ready, wr_ready;
   logic        rd_data_valid = 1'b0;
   logic        result_valid  = 1'b0;
   logic        rd_req, wr_req, busy, done;
   logic [31:0] rd_addr, wr_addr;

   edge_addr_gen #(.MAX_INFLIGHT(MAXI)) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .start         (start),
      .start_raddr   (start_raddr),
      .start_waddr   (start_waddr),
      .img_width     (img_width),
      .img_height    (img_height),
      .rd_req        (rd_req),
      .rd_addr       (rd_addr),
      .rd_ready      (rd_ready),
      .rd_data_valid (rd_data_valid),
      .result_valid  (result_valid),
      .wr_req        (wr_req),
      .wr_addr       (wr_addr),
      .wr_ready      (wr_ready),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- frame-level model ----------------
   int          m_state = 0;  // 0 idle, 1 running, 2 finishing
   logic [31:0] m_rbase = 0, m_wbase = 0, m_total = 0, m_rd_cnt = 0, m_wr_cnt = 0;
   int          m_inflight = 0, m_pending = 0;
   bit          m_ra, m_wa, m_dv;

   always @(posedge clk) begin
      if (!n_rst) begin
         m_state = 0; m_total = 0; m_rd_cnt = 0; m_wr_cnt = 0;
         m_inflight = 0; m_pending = 0;
      end else begin
         case (m_state)
            0: if (start) begin
               m_rbase    = start_raddr;
               m_wbase    = start_waddr;
               m_total    = ((32'(img_width) + 3) / 4) * 32'(img_height);
               m_rd_cnt   = 0; m_wr_cnt = 0; m_inflight = 0; m_pending = 0;
               m_state    = (m_total == 0) ? 2 : 1;
            end
            1: begin
               m_ra = (m_rd_cnt < m_total) && (m_inflight < MAXI) && rd_ready;
               m_wa = (m_pending > 0) && wr_ready;
               m_dv = rd_data_valid && (m_inflight > 0);
               m_rd_cnt   = m_rd_cnt + 32'(m_ra);
               m_inflight = m_inflight + int'(m_ra) - int'(m_dv);
               if (result_valid && !m_wa)      m_pending = (m_pending < 255) ? m_pending + 1 : 255;
               else if (m_wa && !result_valid) m_pending = m_pending - 1;
               if (m_wa) begin
                  m_wr_cnt = m_wr_cnt + 1;
                  if (m_wr_cnt == m_total) m_state = 2;
               end
            end
            default: m_state = 0;
         endcase
      end
   end

   // ---------------- monitor and per-cycle compare ----------------
   bit          chk_en = 0;
   int          cyc = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0, start_cyc = 0;
   logic        will_acc = 1'b0;
   logic [31:0] rd_log[$], wr_log[$];
   bit          e_rd, e_wr;

   always @(negedge clk) begin
      cyc++;
      will_acc = rd_req & rd_ready;
      if (rd_req === 1'b1 && rd_ready) rd_log.push_back(rd_addr);
      if (wr_req === 1'b1 && wr_ready) begin
         wr_log.push_back(wr_addr);
         last_wr_cyc = cyc;
      end
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (start) start_cyc = cyc;
      if (chk_en) begin
         e_rd = (m_state == 1) && (m_rd_cnt < m_total) && (m_inflight < MAXI);
         e_wr = (m_state == 1) && (m_pending > 0);
         check("busy",   32'(busy),   32'(m_state == 1));
         check("done",   32'(done),   32'(m_state == 2));
         check("rd_req", 32'(rd_req), 32'(e_rd));
         check("wr_req", 32'(wr_req), 32'(e_wr));
         if (e_rd) check("rd_addr", rd_addr, m_rbase + 32'd4 * m_rd_cnt);
         if (e_wr) check("wr_addr", wr_addr, m_wbase + 32'd4 * m_wr_cnt);
      end
   end

   // ---------------- read-return responder ----------------
   bit   auto_resp = 1;
   logic man_dv = 1'b0, man_rv = 1'b0;
   logic [1:0] dv_sr = 2'b00;
   logic rv_d = 1'b0;

   always begin
      @(posedge clk);
      #2;
      rv_d          = dv_sr[1];
      dv_sr         = {dv_sr[0], will_acc};
      rd_data_valid = auto_resp ? dv_sr[1] : man_dv;
      result_valid  = auto_resp ? rv_d : man_rv;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_frame(input logic [31:0] ra, input logic [31:0] wa,
                              input logic [15:0] w, input logic [15:0] h);
      start_raddr = ra; start_waddr = wa; img_width = w; img_height = h;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int max_cycles);
      int d0 = done_cnt;
      int n  = 0;
      while (done_cnt == d0 && n < max_cycles) begin
         tick();
         n++;
      end
      check({name, " done pulse"}, 32'(done_cnt - d0), 32'd1);
   endtask

   task automatic clear_logs();
      rd_log.delete();
      wr_log.delete();
   endtask

   logic [31:0] exp_rd1 [4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
   logic [31:0] exp_wr1 [4] = '{32'h2000, 32'h2004, 32'h2008, 32'h200C};
   logic [31:0] exp_wrap[4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
   int d0;

   initial begin
      n_rst = 1'b0; start = 1'b0; rd_ready = 1'b1; wr_ready = 1'b1;
      start_raddr = '0; start_waddr = '0; img_width = '0; img_height = '0;
      tick(2);
      chk_en = 1;
      check("reset rd_addr", rd_addr, 32'h0);
      check("reset wr_addr", wr_addr, 32'h0);
      check("reset busy",    32'(busy), 32'h0);
      n_rst = 1'b1;
      tick();

      // Basic 8x2 frame: four words per channel.
      clear_logs();
      start_frame(32'h1000, 32'h2000, 16'd8, 16'd2);
      wait_done("basic", 200);
      check("basic rd count", 32'(rd_log.size()), 32'd4);
      check("basic wr count", 32'(wr_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < rd_log.size(); i++) check("basic rd seq", rd_log[i], exp_rd1[i]);
      for (int i = 0; i < 4 && i < wr_log.size(); i++) check("basic wr seq", wr_log[i], exp_wr1[i]);
      check("basic done latency", 32'(done_cyc), 32'(last_wr_cyc + 1));
      tick(4);

      // Credit throttle: no returns, so at most four reads go out.
      auto_resp = 0;
      clear_logs();
      start_frame(32'h4000, 32'h5000, 16'd64, 16'd1);
      tick(20);
      check("credit rd count", 32'(rd_log.size()), 32'd4);
      check("credit rd_req low", 32'(rd_req), 32'd0);
      man_dv = 1'b1;
      tick();
      man_dv = 1'b0;
      tick(3);
      check("credit one more read", 32'(rd_log.size()), 32'd5);
      check("credit rd_req low again", 32'(rd_req), 32'd0);
      man_dv = 1'b1; man_rv = 1'b1;
      tick(16);
      man_dv = 1'b0; man_rv = 1'b0;
      wait_done("credit", 100);
      check("credit rd total", 32'(rd_log.size()), 32'd16);
      check("credit wr total", 32'(wr_log.size()), 32'd16);
      if (wr_log.size() == 16) check("credit last wr", wr_log[15], 32'h503C);
      tick(4);
      auto_resp = 1;

      // Partial trailing word: width 5 -> 2 words per row, 3 rows.
      clear_logs();
      start_frame(32'h6000, 32'h6800, 16'd5, 16'd3);
      wait_done("partial", 200);
      check("partial rd count", 32'(rd_log.size()), 32'd6);
      if (rd_log.size() == 6) check("partial last rd", rd_log[5], 32'h6014);
      if (wr_log.size() == 6) check("partial last wr", wr_log[5], 32'h6814);
      tick(4);

      // Zero width: done one cycle after start, no traffic.
      clear_logs();
      start_frame(32'h0100, 32'h0200, 16'd0, 16'd7);
      wait_done("zero", 10);
      check("zero done latency", 32'(done_cyc), 32'(start_cyc + 1));
      check("zero rd count", 32'(rd_log.size()), 32'd0);
      check("zero wr count", 32'(wr_log.size()), 32'd0);
      tick(4);

      // Write backpressure with three results pending.
      auto_resp = 0; wr_ready = 1'b0;
      clear_logs();
      start_frame(32'h7000, 32'h2000, 16'd16, 16'd1);
      man_rv = 1'b1;
      tick(3);
      man_rv = 1'b0;
      repeat (5) begin
         tick();
         check("bp wr_req held", 32'(wr_req), 32'd1);
         check("bp wr_addr held", wr_addr, 32'h2000);
      end
      man_rv = 1'b1; wr_ready = 1'b1;
      tick();
      man_rv = 1'b0;
      wait_done("backpressure", 50);
      check("bp wr count", 32'(wr_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < wr_log.size(); i++) check("bp wr seq", wr_log[i], exp_wr1[i]);
      tick(6);
      auto_resp = 1;

      // Address wrap, with a second start ignored mid-frame.
      clear_logs();
      d0 = done_cnt;
      start_frame(32'hFFFF_FFF8, 32'h9000, 16'd16, 16'd1);
      tick();
      start_frame(32'h5000, 32'h6000, 16'd4, 16'd1);
      wait_done("wrap", 100);
      tick(5);
      check("wrap single done", 32'(done_cnt - d0), 32'd1);
      check("wrap rd count", 32'(rd_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < rd_log.size(); i++) check("wrap rd seq", rd_log[i], exp_wrap[i]);
      if (wr_log.size() > 0) check("wrap first wr", wr_log[0], 32'h9000);

      // Reset mid-frame after two read accepts.
      clear_logs();
      rd_ready = 1'b0;
      start_frame(32'h7000, 32'hA000, 16'd64, 16'd1);
      rd_ready = 1'b1;
      tick(2);
      rd_ready = 1'b0;
      check("abort rd count", 32'(rd_log.size()), 32'd2);
      n_rst = 1'b0;
      tick();
      check("abort rd_req",  32'(rd_req),  32'd0);
      check("abort wr_req",  32'(wr_req),  32'd0);
      check("abort busy",    32'(busy),    32'd0);
      check("abort rd_addr", rd_addr, 32'h0);
      check("abort wr_addr", wr_addr, 32'h0);
      n_rst = 1'b1;
      d0 = done_cnt;
      tick(8);
      check("abort no done", 32'(done_cnt - d0), 32'd0);
      clear_logs();
      rd_ready = 1'b1;
      start_frame(32'h8000, 32'hB000, 16'd8, 16'd1);
      wait_done("after abort", 100);
      check("after abort rd count", 32'(rd_log.size()), 32'd2);
      if (rd_log.size() == 2) check("after abort rd1", rd_log[1], 32'h8004);
      if (wr_log.size() == 2) check("after abort wr0", wr_log[0], 32'hB000);

      tick(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
